intr_ctrl: RTL and testbench

- Interrupt controller directly upstream of the processor `top`.
- Samples the 18 external interrupt lines and latches rising edges into pending bits.
- Applies per-line and global enables, then presents one prioritized request and vector to the core's control unit.
- Single outstanding interrupt; no nesting; req/ack/done handshake with the core.

---
 rtl/intr_ctrl.sv | 167 ++++++++++++++++
 tb/tb_intr_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Purpose : edge-latched, maskable, fixed-priority interrupt controller for a single-issue core.
// Latency : line rises before edge E0 -> pend at E0 -> intr_req after E1 (line enabled, glob_ie=1, idle).
// Backpressure: one request outstanding; intr_req/intr_vec hold until intr_ack (or glob_ie drops); no nesting.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   in_intp[N_IRQ]      raw edge-triggered interrupt lines
//   glob_ie             global interrupt enable from the core
//   en_we, en_wdata     per-line enable mask write port
//   intr_ack, intr_done core handshake pulses (accepted / ISR finished)
//   intr_req, intr_vec  prioritized request and its line index
//   pend, en_mask, busy status visible to the core
module intr_ctrl #(
    parameter int N_IRQ = 18,
    parameter int VEC_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] in_intp,
    input  logic             glob_ie,
    input  logic             en_we,
    input  logic [N_IRQ-1:0] en_wdata,
    input  logic             intr_ack,
    input  logic             intr_done,
    output logic             intr_req,
    output logic [VEC_W-1:0] intr_vec,
    output logic [N_IRQ-1:0] pend,
    output logic [N_IRQ-1:0] en_mask,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_nxt;

    logic [N_IRQ-1:0]   in_prev;
    // Cleared by reset, set on the first edge after reset release. Lines that
    // are already high when reset lifts load into in_prev during that first
    // cycle instead of being seen as fresh rising edges.
    logic               arm_q;

    logic [N_IRQ-1:0]   rise;
    logic [N_IRQ-1:0]   eligible;
    logic               any_elig;
    logic [VEC_W-1:0]   top_idx;

    logic               req_nxt;
    logic [VEC_W-1:0]   vec_nxt;
    logic               busy_nxt;
    logic [N_IRQ-1:0]   pend_clr;
    logic [N_IRQ-1:0]   pend_nxt;

    // Lowest set index wins; scanning downward lets the last hit be the lowest.
    function automatic logic [VEC_W-1:0] lowest_idx(input logic [N_IRQ-1:0] v);
        logic [VEC_W-1:0] idx;
        idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = VEC_W'(i);
            end
        end
        return idx;
    endfunction

    assign rise     = arm_q ? (in_intp & ~in_prev) : '0;
    assign eligible = pend & en_mask;
    assign any_elig = |eligible;
    assign top_idx  = lowest_idx(eligible);

    // Set beats clear so an event arriving with the ack of the same line survives.
    assign pend_nxt = (pend & ~pend_clr) | rise;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            in_prev  <= '0;
            arm_q    <= 1'b0;
            pend     <= '0;
            en_mask  <= '0;
            intr_req <= 1'b0;
            intr_vec <= '0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            in_prev  <= in_intp;
            arm_q    <= 1'b1;
            pend     <= pend_nxt;
            if (en_we) begin
                en_mask <= en_wdata;
            end
            intr_req <= req_nxt;
            intr_vec <= vec_nxt;
            busy     <= busy_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (glob_ie && any_elig) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // Ack has priority over a simultaneous glob_ie drop.
                if (intr_ack) begin
                    state_nxt = SERVICE;
                end else if (!glob_ie) begin
                    state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (intr_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath-update logic.
    always_comb begin
        req_nxt  = intr_req;
        vec_nxt  = intr_vec;
        busy_nxt = busy;
        pend_clr = '0;
        case (state_q)
            IDLE: begin
                if (glob_ie && any_elig) begin
                    req_nxt = 1'b1;
                    vec_nxt = top_idx;
                end
            end
            REQ: begin
                // intr_vec stays frozen here even if a higher-priority line
                // arrives or the requested line is masked off.
                if (intr_ack) begin
                    req_nxt  = 1'b0;
                    busy_nxt = 1'b1;
                    for (int i = 0; i < N_IRQ; i++) begin
                        pend_clr[i] = (intr_vec == VEC_W'(i));
                    end
                end else if (!glob_ie) begin
                    req_nxt = 1'b0;
                end
            end
            SERVICE: begin
                if (intr_done) begin
                    busy_nxt = 1'b0;
                end
            end
            default: begin
                req_nxt  = 1'b0;
                busy_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Purpose : directed self-checking bench for intr_ctrl.
// Latency : inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: the bench plays the core, pulsing intr_ack / intr_done for exactly one cycle.
module tb_intr_ctrl;

    localparam int N_IRQ = 18;
    localparam int VEC_W = 5;

    logic             clk;
    logic             rst;
    logic [N_IRQ-1:0] in_intp;
    logic             glob_ie;
    logic             en_we;
    logic [N_IRQ-1:0] en_wdata;
    logic             intr_ack;
    logic             intr_done;
    logic             intr_req;
    logic [VEC_W-1:0] intr_vec;
    logic [N_IRQ-1:0] pend;
    logic [N_IRQ-1:0] en_mask;
    logic             busy;

    int n_chk;
    int n_pass;

    intr_ctrl #(.N_IRQ(N_IRQ), .VEC_W(VEC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_intp   (in_intp),
        .glob_ie   (glob_ie),
        .en_we     (en_we),
        .en_wdata  (en_wdata),
        .intr_ack  (intr_ack),
        .intr_done (intr_done),
        .intr_req  (intr_req),
        .intr_vec  (intr_vec),
        .pend      (pend),
        .en_mask   (en_mask),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; stimulus and sampling happen 1 unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
    endtask

    task automatic pulse_done();
        intr_done = 1'b1;
        tick();
        intr_done = 1'b0;
    endtask

    task automatic write_mask(input logic [N_IRQ-1:0] m);
        en_we    = 1'b1;
        en_wdata = m;
        tick();
        en_we    = 1'b0;
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b0;
        in_intp   = 18'h3FFFF;
        glob_ie   = 1'b0;
        en_we     = 1'b0;
        en_wdata  = '0;
        intr_ack  = 1'b0;
        intr_done = 1'b0;
        #1;

        // Reset with every line high.
        tick();
        tick();
        chk("rst_req",  32'(intr_req), 32'd0);
        chk("rst_vec",  32'(intr_vec), 32'd0);
        chk("rst_pend", 32'(pend),     32'd0);
        chk("rst_mask", 32'(en_mask),  32'd0);
        chk("rst_busy", 32'(busy),     32'd0);
        rst = 1'b1;
        tick();
        tick();
        chk("rel_no_pend", 32'(pend), 32'd0);
        in_intp = '0;
        tick();

        // Single line 2.
        glob_ie = 1'b1;
        write_mask(18'h3FFFF);
        chk("mask_all", 32'(en_mask), 32'h3FFFF);
        in_intp = 18'd4;
        tick();
        chk("s_pend_e0", 32'(pend),     32'd4);
        chk("s_req_e0",  32'(intr_req), 32'd0);
        tick();
        chk("s_req_e1",  32'(intr_req), 32'd1);
        chk("s_vec_e1",  32'(intr_vec), 32'd2);
        pulse_ack();
        chk("s_pend_ack", 32'(pend),     32'd0);
        chk("s_busy_ack", 32'(busy),     32'd1);
        chk("s_req_ack",  32'(intr_req), 32'd0);
        chk("s_vec_hold", 32'(intr_vec), 32'd2);
        in_intp = '0;
        pulse_ack();    // stray ack in SERVICE
        chk("stray_ack_busy", 32'(busy), 32'd1);
        pulse_done();
        chk("s_busy_done", 32'(busy), 32'd0);
        tick();
        tick();
        chk("s_no_req", 32'(intr_req), 32'd0);

        // Priority: lines 0 and 2 together.
        in_intp = 18'd5;
        tick();
        chk("p_pend", 32'(pend), 32'd5);
        in_intp = '0;
        tick();
        chk("p_req0", 32'(intr_req), 32'd1);
        chk("p_vec0", 32'(intr_vec), 32'd0);
        pulse_ack();
        chk("p_pend_after0", 32'(pend), 32'd4);
        pulse_done();
        chk("p_req_gap", 32'(intr_req), 32'd0);
        tick();
        chk("p_req2", 32'(intr_req), 32'd1);
        chk("p_vec2", 32'(intr_vec), 32'd2);
        pulse_ack();
        pulse_done();
        chk("p_pend_empty", 32'(pend), 32'd0);

        // Masking.
        write_mask('0);
        in_intp = 18'h80;
        tick();
        in_intp = '0;
        tick();
        tick();
        chk("m_pend7", 32'(pend),     32'h80);
        chk("m_noreq", 32'(intr_req), 32'd0);
        write_mask(18'h80);
        chk("m_req_not_yet", 32'(intr_req), 32'd0);
        tick();
        chk("m_req", 32'(intr_req), 32'd1);
        chk("m_vec", 32'(intr_vec), 32'd7);
        pulse_ack();
        pulse_done();

        // Global enable.
        glob_ie = 1'b0;
        write_mask(18'h3FFFF);
        in_intp = 18'd8;
        tick();
        in_intp = '0;
        tick();
        tick();
        chk("g_noreq", 32'(intr_req), 32'd0);
        glob_ie = 1'b1;
        tick();
        chk("g_req", 32'(intr_req), 32'd1);
        chk("g_vec", 32'(intr_vec), 32'd3);
        glob_ie = 1'b0;
        tick();
        chk("g_withdraw", 32'(intr_req), 32'd0);
        chk("g_pend_kept", 32'(pend), 32'd8);
        glob_ie = 1'b1;
        tick();
        chk("g_rereq", 32'(intr_req), 32'd1);
        pulse_ack();
        pulse_done();

        // Collision of a new rise with the ack of the same line.
        in_intp = 18'd2;
        tick();
        in_intp = '0;
        tick();
        chk("c_vec", 32'(intr_vec), 32'd1);
        in_intp = 18'd2;
        pulse_ack();
        in_intp = '0;
        chk("c_pend_kept", 32'(pend), 32'd2);
        chk("c_busy",      32'(busy), 32'd1);
        pulse_done();
        tick();
        chk("c_rereq", 32'(intr_req), 32'd1);
        chk("c_revec", 32'(intr_vec), 32'd1);
        pulse_ack();
        chk("c_busy2", 32'(busy), 32'd1);

        // Reset in the middle of service.
        in_intp = 18'd1;
        tick();
        chk("r_pend_pre", 32'(pend), 32'd1);
        rst = 1'b0;
        tick();
        chk("r_req",  32'(intr_req), 32'd0);
        chk("r_vec",  32'(intr_vec), 32'd0);
        chk("r_pend", 32'(pend),     32'd0);
        chk("r_mask", 32'(en_mask),  32'd0);
        chk("r_busy", 32'(busy),     32'd0);
        rst = 1'b1;
        in_intp = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
